// File: rtl/icache_assoc_if.sv
// Fetch/refill bus bundle for icache_assoc.
//
// Purpose: groups the IFU fetch channel and the memory read channel so the
// cache takes a single bundle port.
//
// Ports (signals):
//   ifu_arvalid/ifu_arready/ifu_raddr          fetch request (word address)
//   ifu_rvalid/ifu_rready/ifu_rdata/ifu_rresp  fetch response
//   mem_arvalid/mem_arready/mem_araddr/mem_arlen  refill burst request
//   mem_rvalid/mem_rready/mem_rdata/mem_rresp/mem_rlast  refill beats
//
// Modports:
//   master : the cache side (answers the IFU, issues memory requests)
//   slave  : the environment side (IFU plus memory)
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both high. A source holding valid keeps its
// payload stable until that edge. Ready never depends on valid.
interface icache_assoc_if #(
  parameter int ADDR_LEN = 32,
  parameter int BUS_LEN  = 32
);
  logic                ifu_arvalid;
  logic                ifu_arready;
  logic [ADDR_LEN-3:0] ifu_raddr;
  logic                ifu_rvalid;
  logic                ifu_rready;
  logic [31:0]         ifu_rdata;
  logic [2:0]          ifu_rresp;

  logic                mem_arvalid;
  logic                mem_arready;
  logic [ADDR_LEN-1:0] mem_araddr;
  logic [7:0]          mem_arlen;
  logic                mem_rvalid;
  logic                mem_rready;
  logic [BUS_LEN-1:0]  mem_rdata;
  logic [2:0]          mem_rresp;
  logic                mem_rlast;

  modport master (
    input  ifu_arvalid, ifu_raddr, ifu_rready,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rresp, mem_rlast,
    output ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp,
    output mem_arvalid, mem_araddr, mem_arlen, mem_rready
  );

  modport slave (
    output ifu_arvalid, ifu_raddr, ifu_rready,
    output mem_arready, mem_rvalid, mem_rdata, mem_rresp, mem_rlast,
    input  ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp,
    input  mem_arvalid, mem_araddr, mem_arlen, mem_rready
  );
endinterface

// File: rtl/icache_assoc.sv
// Parametrised set-associative instruction cache.
//
// Purpose: serves IFU fetches from WAY_NUM x SET_NUM lines, refilling a
// missing line as one burst, with per-set round-robin replacement, whole-cache
// invalidation (fence.i) and hardware hit/access counters.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   bus         icache_assoc_if.master (fetch + refill channels)
//   flush_req   level request to invalidate every line (serviced in IDLE)
//   flush_ack   one-cycle pulse per IDLE cycle that performs the invalidation
//   hit_cnt     completed hits, wraps
//   access_cnt  accepted requests, wraps
//   dbg_state   current FSM state (0 IDLE, 1 MISS_AR, 2 MISS_R, 3 RESP)
module icache_assoc #(
  parameter int ADDR_LEN   = 32,
  parameter int WAY_NUM    = 4,
  parameter int SET_NUM    = 64,
  parameter int LINE_WORDS = 4,
  parameter int BUS_LEN    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  icache_assoc_if.master       bus,
  input  logic                 flush_req,
  output logic                 flush_ack,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          access_cnt,
  output logic [1:0]           dbg_state
);
  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int WOFF_W = OFF_W - 2;
  localparam int IDX_W  = $clog2(SET_NUM);
  localparam int TAG_W  = ADDR_LEN - IDX_W - OFF_W;
  localparam int BEATS  = LINE_WORDS * 32 / BUS_LEN;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int WAY_W  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int LINE_W = LINE_WORDS * 32;

  typedef enum logic [1:0] {S_IDLE, S_MISS_AR, S_MISS_R, S_RESP} state_t;

  state_t r_state, w_next;

  logic [WAY_NUM-1:0] r_valid [SET_NUM];
  logic [WAY_W-1:0]   r_rr    [SET_NUM];
  logic [TAG_W-1:0]   r_tag   [SET_NUM][WAY_NUM];
  logic [LINE_W-1:0]  r_line  [SET_NUM][WAY_NUM];

  logic [ADDR_LEN-3:0] r_addr;
  logic [WAY_W-1:0]    r_hit_way;
  logic                r_from_fill;
  logic                r_err;
  logic [BEAT_W-1:0]   r_beat;
  logic [LINE_W-1:0]   r_fill;
  logic [31:0]         r_hit_cnt;
  logic [31:0]         r_acc_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic              w_accept;
  logic              w_beat;
  logic              w_last;
  logic              w_beat_err;
  logic              w_fill_ok;
  logic [LINE_W-1:0] w_new_line;
  logic [LINE_W-1:0] w_resp_line;
  logic [IDX_W-1:0]  w_r_idx;
  logic [TAG_W-1:0]  w_r_tag;
  logic [WOFF_W-1:0] w_r_woff;
  logic [WAY_W-1:0]  w_victim;

  assign w_idx    = bus.ifu_raddr[WOFF_W +: IDX_W];
  assign w_tag    = bus.ifu_raddr[ADDR_LEN-3 -: TAG_W];
  assign w_r_idx  = r_addr[WOFF_W +: IDX_W];
  assign w_r_tag  = r_addr[ADDR_LEN-3 -: TAG_W];
  assign w_r_woff = r_addr[WOFF_W-1:0];
  assign w_victim = r_rr[w_r_idx];

  // Tag lookup on the incoming index; the first matching valid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (!w_hit && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  assign w_accept = bus.ifu_arvalid & bus.ifu_arready;
  // mem_rready is tied high, so a beat is simply rvalid while refilling.
  assign w_beat   = bus.mem_rvalid & (r_state == S_MISS_R);
  assign w_last   = w_beat & bus.mem_rlast;
  // Bad response, a beat past the line end, or rlast on the wrong beat.
  assign w_beat_err = (bus.mem_rresp != 3'd0) ||
                      (r_beat >= BEAT_W'(BEATS)) ||
                      (bus.mem_rlast && (r_beat != BEAT_W'(BEATS - 1)));
  assign w_fill_ok = w_last & ~r_err & ~w_beat_err;

  // Fill buffer with the current beat merged in, so the last beat can be
  // installed in the same cycle it arrives.
  always_comb begin
    w_new_line = r_fill;
    if (r_beat < BEAT_W'(BEATS)) begin
      w_new_line[int'(r_beat) * BUS_LEN +: BUS_LEN] = bus.mem_rdata;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = w_hit ? S_RESP : S_MISS_AR;
      S_MISS_AR: if (bus.mem_arready) w_next = S_MISS_R;
      S_MISS_R:  if (w_last) w_next = S_RESP;
      S_RESP:    if (bus.ifu_rready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.ifu_arready = (r_state == S_IDLE) & ~flush_req;
    bus.ifu_rvalid  = (r_state == S_RESP);
    bus.ifu_rresp   = ((r_state == S_RESP) && r_err) ? 3'd2 : 3'd0;
    bus.mem_arvalid = (r_state == S_MISS_AR);
    flush_ack       = (r_state == S_IDLE) & flush_req;
  end

  assign w_resp_line   = r_from_fill ? r_fill : r_line[w_r_idx][r_hit_way];
  assign bus.ifu_rdata = w_resp_line[int'(w_r_woff) * 32 +: 32];
  assign bus.mem_araddr = {r_addr[ADDR_LEN-3:WOFF_W], {OFF_W{1'b0}}};
  assign bus.mem_arlen  = 8'(BEATS - 1);
  assign bus.mem_rready = 1'b1;
  assign hit_cnt    = r_hit_cnt;
  assign access_cnt = r_acc_cnt;
  assign dbg_state  = r_state;

  // Control, valid bits, replacement pointers and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_hit_way   <= '0;
      r_from_fill <= 1'b0;
      r_err       <= 1'b0;
      r_beat      <= '0;
      r_hit_cnt   <= '0;
      r_acc_cnt   <= '0;
      for (int s = 0; s < SET_NUM; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      if (w_accept) begin
        r_addr      <= bus.ifu_raddr;
        r_hit_way   <= w_hit_way;
        r_from_fill <= ~w_hit;
        r_err       <= 1'b0;
        r_beat      <= '0;
        r_acc_cnt   <= r_acc_cnt + 32'd1;
        if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_beat) begin
        r_err <= r_err | w_beat_err;
        if (r_beat < BEAT_W'(BEATS)) r_beat <= r_beat + 1'b1;
      end
      if (w_fill_ok) begin
        r_valid[w_r_idx][w_victim] <= 1'b1;
        r_rr[w_r_idx] <= (w_victim == WAY_W'(WAY_NUM - 1)) ? '0 : w_victim + 1'b1;
      end
      if (flush_ack) begin
        for (int s = 0; s < SET_NUM; s++) r_valid[s] <= '0;
      end
    end
  end

  // Line storage needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (w_beat) r_fill <= w_new_line;
    if (w_fill_ok) begin
      r_tag[w_r_idx][w_victim]  <= w_r_tag;
      r_line[w_r_idx][w_victim] <= w_new_line;
    end
  end
endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
Parametrised set-associative instruction cache between the IFU fetch channel and the memory read channel. It generalises the current fixed 4-way, 16-byte-line icache to configurable ways, sets, line size and bus width. It issues the line refill as a single burst with rlast, uses deterministic per-set round-robin replacement, and supports whole-cache invalidation for fence.i. It also provides hit and access counters in hardware instead of simulation hooks.

Parameters:
ADDR_LEN, 32, address width in bits.
WAY_NUM, 4, associativity; power of 2, range 1..8.
SET_NUM, 64, number of sets; power of 2.
LINE_WORDS, 4, 32-bit words per line; power of 2, range 2..16.
BUS_LEN, 32, memory data width; 32 or 64.
Derived: OFF_W=log2(LINE_WORDS)+2, IDX_W=log2(SET_NUM), TAG_W=ADDR_LEN-IDX_W-OFF_W, BEATS=LINE_WORDS*32/BUS_LEN.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
ifu_arvalid  in  1  fetch request valid
ifu_arready  out  1  cache can accept a request
ifu_raddr  in  ADDR_LEN-2  word address [ADDR_LEN-1:2]
ifu_rvalid  out  1  instruction valid
ifu_rready  in  1  IFU accepts the instruction
ifu_rdata  out  32  instruction word
ifu_rresp  out  3  0=OKAY, 2=SLVERR
mem_arvalid  out  1  refill request valid
mem_arready  in  1  memory accepts the request
mem_araddr  out  ADDR_LEN  line-aligned refill address
mem_arlen  out  8  BEATS-1, constant
mem_rvalid  in  1  beat valid
mem_rready  out  1  tied high
mem_rdata  in  BUS_LEN  beat data
mem_rresp  in  3  beat response
mem_rlast  in  1  last beat of the burst
flush_req  in  1  invalidate the whole cache (level signal)
flush_ack  out  1  one-cycle pulse when the invalidation is done
hit_cnt  out  32  completed hits, wraps
access_cnt  out  32  accepted requests, wraps

Behaviour:
- Reset (async, active-high):
  - State is IDLE; all valid bits are 0; all round-robin pointers are 0; both counters are 0.
  - ifu_arready=1; ifu_rvalid=0; ifu_rresp=0; mem_arvalid=0; flush_ack=0.
  - Reset asserted mid-refill abandons the burst; no partial line is installed.
- Storage:
  - Per set and per way: valid bit, tag and line data, held in flops or a behavioural array.
  - Tag compare is combinational on the incoming index when the request is accepted.
- States:
  - IDLE: ifu_arready = ~flush_req.
    - flush_req=1: clear all valid bits and pulse flush_ack this cycle. flush_req has priority over ifu_arvalid, because arready is 0.
    - Handshake with a hit: latch the address and hit way, access_cnt+1, hit_cnt+1, go to RESP. ifu_rvalid rises the next cycle, giving 1-cycle hit latency.
    - Handshake with a miss: latch the address, access_cnt+1, go to MISS_AR. mem_arvalid=1 from the next cycle with mem_araddr={tag,index,OFF_W'b0}.
  - MISS_AR: hold mem_arvalid and the address stable until mem_arready, then go to MISS_R.
  - MISS_R:
    - Each mem_rvalid beat shifts into the fill buffer in ascending order (beat 0 = offset 0).
    - Any beat with a nonzero rresp sets a sticky error flag.
    - On the beat with rlast:
      - No error: write the line into the way at rr_ptr[index], set valid, rr_ptr[index]+1 (mod WAY_NUM), ifu_rresp=0, go to RESP.
      - Error: install nothing and leave rr_ptr unchanged; ifu_rresp=2, go to RESP.
    - If rlast arrives before BEATS beats, the burst ends anyway; an early rlast is treated as an error.
  - RESP: ifu_rvalid=1, with ifu_rdata = word[offset] taken from the hit way or the fill buffer. On rready, go to IDLE with rvalid=0 and arready=1 in the next cycle. The next request needs that bubble cycle; there is no back-to-back acceptance.
- Flush:
  - flush_req outside IDLE waits; the flush is serviced on the first IDLE cycle.
  - Each IDLE cycle with flush_req=1 produces one flush_ack pulse.
  - A refill already in flight completes and installs its line, and is then invalidated by the flush.
- Constraints:
  - WAY_NUM=1 degenerates to direct-mapped, with rr_ptr always 0.
  - mem_rvalid outside MISS_R is ignored.
  - Counters wrap from 0xFFFFFFFF to 0.

Test Plan:
1. Reset, then fetch 0x80000000 with memory returning words 0x11,0x22,0x33,0x44 -> one burst at 0x80000000 with arlen=3; rdata=0x11, rresp=0; access_cnt=1, hit_cnt=0.
2. Fetch 0x8000000C after test 1 -> no mem_arvalid; rvalid exactly 1 cycle after the handshake; rdata=0x44; hit_cnt=1.
3. Fill five lines mapping to set 0 (stride SET_NUM*LINE_WORDS*4, WAY_NUM=4) -> the fifth refill evicts way 0; refetching the first line misses while lines 2-4 hit.
4. Refill whose beat 2 has rresp=2 -> ifu_rresp=2; refetching the same address misses again; rr_ptr unchanged.
5. Assert flush_req while in MISS_R -> flush_ack occurs only after the RESP handshake; every subsequent fetch misses.
6. BUS_LEN=64, LINE_WORDS=8 -> arlen=3 (4 beats); offset 5 returns the upper half of beat 2; ifu_rready held low for 10 cycles keeps rvalid and rdata stable.
